// File: rtl/bin_ctr_seq.sv
// Command sequencer for a universal binary counter: expands clear/load/count
// commands into cycle-exact syn_clr/load/en/up/d control waveforms.
module bin_ctr_seq #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] cmd_arg,
  output logic         cmd_ready,
  input  logic         abort,
  output logic         syn_clr,
  output logic         load,
  output logic         en,
  output logic         up,
  output logic [N-1:0] d,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {StIdle, StClr, StLoad, StCount} state_e;

  localparam logic [N-1:0] CntOne = N'(1);

  state_e         state_q, state_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N-1:0]   d_q, d_d;
  logic           up_q, up_d;
  logic           done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
      d_q     <= '0;
      up_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      d_q     <= d_d;
      up_q    <= up_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    d_d     = d_q;
    up_d    = up_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'b00: state_d = StClr;
            2'b01: begin
              state_d = StLoad;
              d_d     = cmd_arg;
            end
            default: begin
              // A zero-length count completes immediately without leaving idle.
              if (cmd_arg == '0) begin
                done_d = 1'b1;
              end else begin
                state_d = StCount;
                rem_d   = cmd_arg;
                up_d    = ~cmd_op[0];
              end
            end
          endcase
        end
      end
      StClr, StLoad: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      StCount: begin
        if (rem_q == CntOne) begin
          state_d = StIdle;
          rem_d   = '0;
          up_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          rem_d = rem_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort overrides normal completion and suppresses done; d is kept.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      rem_d   = '0;
      up_d    = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    syn_clr   = (state_q == StClr);
    load      = (state_q == StLoad);
    en        = (state_q == StCount);
    up        = (state_q == StCount) && up_q;
    d         = d_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_bin_ctr_seq.sv
// Directed self-checking bench for bin_ctr_seq with a behavioural counter
// model driven from the sequencer's control outputs.
module tb_bin_ctr_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       cmd_ready;
  logic       abort;
  logic       syn_clr, load, en, up, busy, done;
  logic [7:0] d;

  int checks = 0;
  int failures = 0;

  bin_ctr_seq #(.N(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cmd_ready (cmd_ready),
    .abort     (abort),
    .syn_clr   (syn_clr),
    .load      (load),
    .en        (en),
    .up        (up),
    .d         (d),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Counter under control plus running totals of control activity.
  logic [7:0] cnt = 8'h55;
  int en_tot = 0;
  int done_tot = 0;
  int busy_tot = 0;

  always @(posedge clk) begin
    if (syn_clr) cnt <= 8'h00;
    else if (load) cnt <= d;
    else if (en) cnt <= up ? cnt + 8'h01 : cnt - 8'h01;
    en_tot   <= en_tot + int'(en);
    done_tot <= done_tot + int'(done);
    busy_tot <= busy_tot + int'(busy);
  end

  // Invariants checked every cycle.
  always @(negedge clk) begin
    checks++;
    assert ((int'(syn_clr) + int'(load) + int'(en)) <= 1 && !(up && !en) && !(done && busy))
    else begin
      failures++;
      $error("FAIL invariant: got clr=%0b ld=%0b en=%0b up=%0b done=%0b busy=%0b", syn_clr,
             load, en, up, done, busy);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, {syn_clr, load, en, up, busy}, 5'b00000);
    chk({tag, "_ready"}, cmd_ready, 1'b1);
  endtask

  int e0, d0, b0;

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_arg = 8'h00;
    abort = 1'b0;

    // Reset
    tick();
    chk_idle("rst1");
    chk("rst1_d", d, 8'h00);
    chk("rst1_done", done, 1'b0);
    tick();
    chk_idle("rst2");
    reset = 1'b0;

    // Clear
    cmd_valid = 1'b1; cmd_op = 2'b00;
    tick();
    chk("clr_ctl", {syn_clr, load, en, busy, cmd_ready, done}, 6'b100100);
    cmd_valid = 1'b0;
    tick();
    chk("clr_end", {syn_clr, busy, cmd_ready, done}, 4'b0011);
    tick();
    chk("clr_done_off", done, 1'b0);

    // Load 3; arg changes afterwards must not disturb d
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 8'h03;
    tick();
    chk("ld_ctl", {syn_clr, load, en, busy}, 4'b0101);
    chk("ld_d", d, 8'h03);
    cmd_valid = 1'b0; cmd_arg = 8'hff;
    tick();
    chk("ld_end", {load, done, cmd_ready}, 3'b011);
    tick();
    chk("ld_d_hold", d, 8'h03);
    chk("ld_cnt", cnt, 8'h03);

    // Clear, then count up 12
    cmd_valid = 1'b1; cmd_op = 2'b00;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("clr2_cnt", cnt, 8'h00);
    e0 = en_tot; d0 = done_tot;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_arg = 8'd12;
    tick();
    chk("up_start", {en, up, busy, cmd_ready}, 4'b1110);
    cmd_valid = 1'b0;
    repeat (11) tick();
    chk("up_last", {en, up, done}, 3'b110);
    tick();
    chk("up_end", {en, up, done, busy}, 4'b0010);
    chk("up_en_cycles", en_tot - e0, 12);
    chk("up_cnt", cnt, 8'd12);
    tick();
    chk("up_done_cnt", done_tot - d0, 1);

    // Count down 6
    e0 = en_tot; d0 = done_tot;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_arg = 8'd6;
    tick();
    chk("dn_start", {en, up, busy}, 3'b101);
    cmd_valid = 1'b0;
    repeat (6) tick();
    chk("dn_end", {en, done}, 2'b01);
    tick();
    chk("dn_en_cycles", en_tot - e0, 6);
    chk("dn_done_cnt", done_tot - d0, 1);
    chk("dn_cnt", cnt, 8'd6);

    // Zero-length count
    e0 = en_tot; d0 = done_tot; b0 = busy_tot;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_arg = 8'd0;
    tick();
    chk("z_first", {en, busy, cmd_ready, done}, 4'b0011);
    cmd_valid = 1'b0;
    tick();
    chk("z_done_off", done, 1'b0);
    chk("z_en", en_tot - e0, 0);
    chk("z_busy", busy_tot - b0, 0);
    chk("z_done_cnt", done_tot - d0, 1);

    // Abort after 4 enabled cycles
    e0 = en_tot; d0 = done_tot;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_arg = 8'd10;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    chk("ab_pre", en, 1'b1);
    abort = 1'b1;
    tick();
    chk_idle("ab_post");
    chk("ab_done", done, 1'b0);
    abort = 1'b0;
    tick();
    chk("ab_done_cnt", done_tot - d0, 0);
    chk("ab_en_cycles", en_tot - e0, 4);
    chk("ab_cnt", cnt, 8'd10);
    chk("ab_d_keep", d, 8'h03);

    // Abort in idle together with a command: command wins
    abort = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00;
    tick();
    chk("abi_acc", {syn_clr, busy}, 2'b11);
    abort = 1'b0; cmd_valid = 1'b0;
    tick();
    chk("abi_done", done, 1'b1);
    tick();
    chk("abi_cnt", cnt, 8'h00);

    // Streaming with valid held high, reset mid-count
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 8'd5;
    tick();
    chk("st_ld", {load, d}, {1'b1, 8'd5});
    cmd_op = 2'b10; cmd_arg = 8'd20;
    tick();
    chk("st_ld_done", {load, done, cmd_ready}, 3'b011);
    tick();
    chk("st_up", {en, up, done}, 3'b110);
    cmd_op = 2'b11; cmd_arg = 8'd3;
    repeat (4) tick();
    chk("st_up_mid", en, 1'b1);
    reset = 1'b1;
    tick();
    chk_idle("st_rst1");
    chk("st_rst1_d", {d, done}, 9'd0);
    tick();
    chk_idle("st_rst2");
    reset = 1'b0;
    tick();
    chk("st_dn", {en, up, busy}, 3'b101);
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("st_dn_last", en, 1'b1);
    tick();
    chk("st_dn_end", {en, done}, 2'b01);
    chk("st_cnt", cnt, 8'd7);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
